// File: rtl/uart_rx_deserializer_if.sv
// Bus between the UART receive path and its surroundings: the serial line,
// frame configuration, received word and frame-end status strobes.
interface uart_rx_deserializer_if #(
    parameter int P_Width = 8
);
    logic               RX_IN;
    logic [5:0]         Prescale;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic [P_Width-1:0] P_DATA;
    logic               DATA_VALID;
    logic               PAR_ERR;
    logic               STP_ERR;

    // Side that drives the line and configuration and consumes received words
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    // The receiver itself
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversamples RX_IN, qualifies the start bit,
// shifts in P_Width data bits LSB first, optionally checks parity, checks the
// stop bit and reports the frame with a one-cycle DATA_VALID or error pulse.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop input synchronizer
// (reset value 1), which delays every frame event by 2 cycles.
module uart_rx_deserializer #(
    parameter int P_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_deserializer_if.slave bus
);

    localparam int BW = (P_Width > 1) ? $clog2(P_Width) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q;
    logic [5:0]         edge_q;
    logic [BW-1:0]      bit_q;
    logic [5:0]         n_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_flag_q;
    logic [P_Width-1:0] shreg_q;
    logic [2:0]         smp_q;
    logic [P_Width-1:0] p_data_q;
    logic               dv_q;
    logic               pe_q;
    logic               se_q;

    logic               rx;
    logic [5:0]         n_sel;
    logic [5:0]         half;
    logic [5:0]         edge_d;
    logic               at_s0;
    logic               at_s1;
    logic               at_s2;
    logic               at_dec;
    logic               at_last;
    logic               maj;
    logic               par_exp;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer, idles high so reset does not fake a start bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], bus.RX_IN};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = bus.RX_IN;
`endif

    // Decode the configured oversampling ratio; anything not 16 or 32 runs at 8
    always_comb begin
        unique case (bus.Prescale)
            6'd16:   n_sel = 6'd16;
            6'd32:   n_sel = 6'd32;
            default: n_sel = 6'd8;
        endcase
    end

    // Bit-period positions: three samples around the middle, decision after them
    always_comb begin
        half    = {1'b0, n_q[5:1]};
        edge_d  = edge_q + 6'd1;
        at_s0   = (edge_q == half - 6'd1);
        at_s1   = (edge_q == half);
        at_s2   = (edge_q == half + 6'd1);
        at_dec  = (edge_q == half + 6'd2);
        at_last = (edge_q == n_q - 6'd1);
        maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
        par_exp = par_typ_q ? ~^shreg_q : ^shreg_q;
    end

    // Capture the three mid-bit samples of the current bit period
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp_q <= '0;
        end else if (state_q != IDLE) begin
            if (at_s0) smp_q[0] <= rx;
            if (at_s1) smp_q[1] <= rx;
            if (at_s2) smp_q[2] <= rx;
        end
    end

    // Frame FSM with counters, data shift register and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            n_q        <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            shreg_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            pe_q   <= 1'b0;
            se_q   <= 1'b0;
            edge_q <= edge_d;
            unique case (state_q)
                IDLE: begin
                    edge_q <= '0;
                    if (!rx) begin
                        // The detecting cycle itself is edge 0 of the start bit
                        state_q    <= START;
                        edge_q     <= 6'd1;
                        bit_q      <= '0;
                        n_q        <= n_sel;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_flag_q <= 1'b0;
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                    end else if (at_last) begin
                        state_q <= DATA;
                        edge_q  <= '0;
                    end
                end
                DATA: begin
                    if (at_dec) begin
                        shreg_q <= {maj, shreg_q[P_Width-1:1]};
                    end
                    if (at_last) begin
                        edge_q <= '0;
                        if (bit_q == BW'(P_Width - 1)) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (at_dec) begin
                        par_flag_q <= maj ^ par_exp;
                    end
                    if (at_last) begin
                        state_q <= STOP;
                        edge_q  <= '0;
                    end
                end
                STOP: begin
                    if (at_last) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                        if (maj && !par_flag_q) begin
                            dv_q     <= 1'b1;
                            p_data_q <= shreg_q;
                        end else begin
                            pe_q <= par_flag_q;
                            se_q <= ~maj;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    edge_q  <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = dv_q;
    assign bus.PAR_ERR    = pe_q;
    assign bus.STP_ERR    = se_q;

    // A frame ends either good or flagged, never both
    a_excl_flags: assert property (@(posedge CLK) disable iff (RST)
        !(dv_q && (pe_q || se_q)));

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frames are driven on RX_IN,
// expected frame-end events are queued with their expected cycle and compared
// when the receiver pulses DATA_VALID / PAR_ERR / STP_ERR.
module tb_uart_rx_deserializer;

    localparam int PW = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [2:0]  flags;   // {DATA_VALID, PAR_ERR, STP_ERR}
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    int unsigned cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          cur_n = 8;
    logic        cur_pe = 1'b0;
    logic        cur_pt = 1'b0;
    exp_t        sb[$];
    int unsigned vcyc[$];
    exp_t        me;
    logic [2:0]  mflags;

    uart_rx_deserializer_if #(.P_Width(PW)) bus ();

    uart_rx_deserializer #(.P_Width(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every strobe cycle must match the next queued frame result
    always @(negedge CLK) begin
        mflags = {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR};
        if (RST === 1'b0 && mflags !== 3'b000) begin
            total++;
            if (mflags[2] === 1'b1) vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: flags=%b at cycle %0d, required no pulse", mflags, cyc);
            end else begin
                me = sb.pop_front();
                if (mflags === me.flags && cyc == me.cyc &&
                    (me.flags[2] !== 1'b1 || bus.P_DATA === me.data)) begin
                    passed++;
                end else begin
                    $display("FAIL frame_event: flags=%b cyc=%0d data=%h, required flags=%b cyc=%0d data=%h",
                             mflags, cyc, bus.P_DATA, me.flags, me.cyc, me.data);
                end
            end
        end
    end

    task automatic set_cfg(input logic [5:0] presc, input logic pe, input logic pt, input int eff_n);
        bus.Prescale = presc;
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        cur_n        = eff_n;
        cur_pe       = pe;
        cur_pt       = pt;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Entered and left at a negedge so consecutive calls are back-to-back
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bit, input bit push);
        logic pb;
        logic bad;
        exp_t e;
        pb  = (cur_pt ? ~^d : ^d) ^ par_bad;
        bad = cur_pe & par_bad;
        if (push) begin
            e.flags = (stop_bit && !bad) ? 3'b100 : {1'b0, bad, ~stop_bit};
            e.data  = d;
            e.cyc   = cyc + (2 + PW + int'(cur_pe)) * cur_n + SYNC_LAT;
            sb.push_back(e);
        end
        bus.RX_IN = 1'b0;
        repeat (cur_n) @(negedge CLK);
        for (int i = 0; i < PW; i++) begin
            bus.RX_IN = d[i];
            repeat (cur_n) @(negedge CLK);
        end
        if (cur_pe) begin
            bus.RX_IN = pb;
            repeat (cur_n) @(negedge CLK);
        end
        bus.RX_IN = stop_bit;
        repeat (cur_n) @(negedge CLK);
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bus.RX_IN = 1'b1;
        set_cfg(6'd8, 1'b0, 1'b0, 8);
        repeat (3) @(negedge CLK);
        total++;
        if ({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== '0) begin
            $display("FAIL reset_outputs: got %h/%b%b%b, required 00/000",
                     bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
        end else passed++;
        RST = 1'b0;
        idle(5);
    endtask

    task automatic test_basic;
        set_cfg(6'd8, 1'b0, 1'b0, 8);
        idle(10);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        idle(32);
        total++;
        if (sb.size() != 0) $display("FAIL basic_pending: got %0d outstanding, required 0", sb.size());
        else passed++;
        total++;
        if (bus.P_DATA !== 8'hA5) $display("FAIL basic_hold: got %h, required a5", bus.P_DATA);
        else passed++;
    endtask

    task automatic test_parity;
        set_cfg(6'd16, 1'b1, 1'b0, 16);
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        idle(40);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(40);
        total++;
        if (bus.P_DATA !== 8'h3C) $display("FAIL parity_hold: got %h, required 3c", bus.P_DATA);
        else passed++;
        set_cfg(6'd16, 1'b1, 1'b1, 16);
        idle(5);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        idle(40);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(40);
        total++;
        if (sb.size() != 0) $display("FAIL parity_pending: got %0d outstanding, required 0", sb.size());
        else passed++;
        total++;
        if (bus.P_DATA !== 8'h07) $display("FAIL odd_parity_hold: got %h, required 07", bus.P_DATA);
        else passed++;
    endtask

    task automatic test_stop_err;
        set_cfg(6'd8, 1'b0, 1'b0, 8);
        idle(10);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(24);
        total++;
        if (bus.P_DATA !== 8'h07) $display("FAIL stop_err_hold: got %h, required 07", bus.P_DATA);
        else passed++;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        idle(24);
        total++;
        if (sb.size() != 0 || bus.P_DATA !== 8'h55)
            $display("FAIL stop_recover: got %h pending %0d, required 55 pending 0", bus.P_DATA, sb.size());
        else passed++;
    endtask

    task automatic test_glitch;
        set_cfg(6'd16, 1'b0, 1'b0, 16);
        idle(10);
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        idle(40);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        idle(40);
        total++;
        if (sb.size() != 0 || bus.P_DATA !== 8'h0F)
            $display("FAIL glitch_recover: got %h pending %0d, required 0f pending 0", bus.P_DATA, sb.size());
        else passed++;
    endtask

    task automatic test_back_to_back;
        set_cfg(6'd32, 1'b0, 1'b0, 32);
        idle(10);
        vcyc.delete();
        send_frame(8'h12, 1'b0, 1'b1, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1, 1'b1);
        idle(64);
        total++;
        if (vcyc.size() != 2) $display("FAIL b2b_count: got %0d pulses, required 2", vcyc.size());
        else if (vcyc[1] - vcyc[0] != 320) $display("FAIL b2b_spacing: got %0d, required 320", vcyc[1] - vcyc[0]);
        else passed++;
        total++;
        if (sb.size() != 0 || bus.P_DATA !== 8'h34)
            $display("FAIL b2b_data: got %h pending %0d, required 34 pending 0", bus.P_DATA, sb.size());
        else passed++;
    endtask

    // Illegal Prescale runs at 8; config changes mid-frame must be ignored
    task automatic test_illegal_prescale;
        set_cfg(6'd5, 1'b0, 1'b0, 8);
        idle(10);
        fork
            send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
            begin
                repeat (20) @(negedge CLK);
                bus.Prescale = 6'd16;
                bus.PAR_EN   = 1'b1;
            end
        join
        set_cfg(6'd8, 1'b0, 1'b0, 8);
        idle(24);
        total++;
        if (sb.size() != 0 || bus.P_DATA !== 8'hC3)
            $display("FAIL illegal_prescale: got %h pending %0d, required c3 pending 0", bus.P_DATA, sb.size());
        else passed++;
    endtask

    task automatic test_mid_reset;
        set_cfg(6'd8, 1'b0, 1'b0, 8);
        idle(10);
        fork
            send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
            begin
                repeat (36) @(negedge CLK);
                RST = 1'b1;
                #1;
                total++;
                if ({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== '0)
                    $display("FAIL mid_reset_outputs: got %h/%b%b%b, required 00/000",
                             bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
                else passed++;
                @(negedge CLK);
                RST = 1'b0;
            end
        join
        idle(24);
        total++;
        if (bus.P_DATA !== 8'h00) $display("FAIL mid_reset_discard: got %h, required 00", bus.P_DATA);
        else passed++;
        send_frame(8'h66, 1'b0, 1'b1, 1'b1);
        idle(24);
        total++;
        if (sb.size() != 0 || bus.P_DATA !== 8'h66)
            $display("FAIL mid_reset_recover: got %h pending %0d, required 66 pending 0", bus.P_DATA, sb.size());
        else passed++;
    endtask

    initial begin
        bus.RX_IN = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_illegal_prescale();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
